// File: rtl/idecoder_pipe_if.sv
// idecoder_pipe_if: fetch-side and execute-side handshake bundle of the decode stage.
interface idecoder_pipe_if #(
    parameter int XLEN = 32
);
    localparam int INST_WIDTH = 32;
    localparam int OPCODE_WIDTH = 7;
    localparam int INST_TYPE_WIDTH = 4;
    localparam int REG_WIDTH = 5;
    localparam int FUNCT_WIDTH = 5;
    logic in_valid;
    logic in_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0] in_pc;
    logic out_valid;
    logic out_ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [XLEN-1:0] imm;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [REG_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic [FUNCT_WIDTH-1:0] funct;
    logic [XLEN-1:0] out_pc;
    logic illegal;
    modport slave (
        input in_valid, inst, in_pc, out_ready,
        output in_ready, out_valid, opcode, imm, inst_type, rd, rs1, rs2, funct, out_pc, illegal
    );
    modport master (
        output in_valid, inst, in_pc, out_ready,
        input in_ready, out_valid, opcode, imm, inst_type, rd, rs1, rs2, funct, out_pc, illegal
    );
endinterface

// File: rtl/idecoder_pipe.sv
// idecoder_pipe: RV32I decoder feeding a DEPTH-entry FIFO toward execute.
// Define IDECODER_ILLEGAL_EN to flag unrecognised encodings on `illegal`.
module idecoder_pipe #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic flush,
    idecoder_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [3:0] T_IMM = 4'd1;
    localparam logic [3:0] T_INT_IMM = 4'd2;
    localparam logic [3:0] T_INT_REG = 4'd3;
    localparam logic [3:0] T_BRANCH = 4'd4;
    localparam logic [3:0] T_AUIPC = 4'd5;
    localparam logic [3:0] T_JAL = 4'd6;
    localparam logic [3:0] T_JALR = 4'd7;
    localparam logic [3:0] T_LOAD = 4'd8;
    localparam logic [3:0] T_STORE = 4'd9;
    localparam logic [3:0] T_FENCE = 4'd10;
    localparam logic [3:0] T_SYSTEM = 4'd11;
    localparam logic [4:0] F_ADD = 5'd1;
    localparam logic [4:0] F_SUB = 5'd2;
    localparam logic [4:0] F_EQ = 5'd3;
    localparam logic [4:0] F_NE = 5'd4;
    localparam logic [4:0] F_LT = 5'd5;
    localparam logic [4:0] F_GE = 5'd6;
    localparam logic [4:0] F_LTU = 5'd7;
    localparam logic [4:0] F_GEU = 5'd8;
    localparam logic [4:0] F_AND = 5'd9;
    localparam logic [4:0] F_OR = 5'd10;
    localparam logic [4:0] F_XOR = 5'd11;
    localparam logic [4:0] F_SLL = 5'd12;
    localparam logic [4:0] F_SRL = 5'd13;
    localparam logic [4:0] F_SRA = 5'd14;
    localparam logic [4:0] F_SLT = 5'd15;
    localparam logic [4:0] F_SLTU = 5'd16;
    localparam logic [4:0] F_MEM_B = 5'd17;
    localparam logic [4:0] F_MEM_H = 5'd18;
    localparam logic [4:0] F_MEM_W = 5'd19;
    localparam logic [4:0] F_MEM_BU = 5'd20;
    localparam logic [4:0] F_MEM_HU = 5'd21;
    localparam logic [4:0] F_ECALL = 5'd22;
    localparam logic [4:0] F_EBREAK = 5'd23;

    typedef struct packed {
        logic [6:0] opcode;
        logic [3:0] inst_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] funct;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    function automatic logic [4:0] alu_funct(input logic [2:0] f3, input logic alt);
        return f3 == 3'b000 ? (alt ? F_SUB : F_ADD) :
               f3 == 3'b001 ? F_SLL :
               f3 == 3'b010 ? F_SLT :
               f3 == 3'b011 ? F_SLTU :
               f3 == 3'b100 ? F_XOR :
               f3 == 3'b101 ? (alt ? F_SRA : F_SRL) :
               f3 == 3'b110 ? F_OR : F_AND;
    endfunction

    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    entry_t dec, entry, head;
    entry_t mem [DEPTH];
    state_t state, state_next;
    logic [CW-1:0] count, count_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic valid, push, pop;

    assign op = bus.inst[6:0];
    assign f3 = bus.inst[14:12];
    assign rd_f = bus.inst[11:7];
    assign rs1_f = bus.inst[19:15];
    assign rs2_f = bus.inst[24:20];
    assign imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
    assign imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
    assign imm_b = {{20{bus.inst[31]}}, bus.inst[7], bus.inst[30:25], bus.inst[11:8], 1'b0};
    assign imm_u = {bus.inst[31:12], 12'b0};
    assign imm_j = {{12{bus.inst[31]}}, bus.inst[19:12], bus.inst[20], bus.inst[30:21], 1'b0};

    always_comb begin
        dec = '0;
        dec.opcode = op;
        dec.pc = bus.in_pc;
        case (op)
            OP_LUI, OP_AUIPC: begin
                dec.inst_type = op == OP_LUI ? T_IMM : T_AUIPC;
                dec.rd = rd_f;
                dec.imm = XLEN'(imm_u);
            end
            OP_JAL: begin
                dec.inst_type = T_JAL;
                dec.rd = rd_f;
                dec.imm = XLEN'(imm_j);
            end
            OP_JALR, OP_FENCE: begin
                dec.inst_type = op == OP_JALR ? T_JALR : T_FENCE;
                dec.rd = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = XLEN'(imm_i);
            end
            OP_BRANCH: begin
                dec.inst_type = T_BRANCH;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.imm = XLEN'(imm_b);
                dec.funct = f3 == 3'b000 ? F_EQ : f3 == 3'b001 ? F_NE : f3 == 3'b100 ? F_LT :
                            f3 == 3'b101 ? F_GE : f3 == 3'b110 ? F_LTU : f3 == 3'b111 ? F_GEU : 5'd0;
            end
            OP_LOAD: begin
                dec.inst_type = T_LOAD;
                dec.rd = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = XLEN'(imm_i);
                dec.funct = f3 == 3'b000 ? F_MEM_B : f3 == 3'b001 ? F_MEM_H : f3 == 3'b010 ? F_MEM_W :
                            f3 == 3'b100 ? F_MEM_BU : f3 == 3'b101 ? F_MEM_HU : 5'd0;
            end
            OP_STORE: begin
                dec.inst_type = T_STORE;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.imm = XLEN'(imm_s);
                dec.funct = f3 == 3'b000 ? F_MEM_B : f3 == 3'b001 ? F_MEM_H : f3 == 3'b010 ? F_MEM_W : 5'd0;
            end
            OP_IMM: begin
                dec.inst_type = T_INT_IMM;
                dec.rd = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = XLEN'(imm_i);
                // only shifts read inst[30]; for ADDI it is an immediate bit, not SUB
                dec.funct = alu_funct(f3, f3 == 3'b101 && bus.inst[30]);
            end
            OP_REG: begin
                dec.inst_type = T_INT_REG;
                dec.rd = rd_f;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.funct = alu_funct(f3, bus.inst[30]);
            end
            OP_SYSTEM: begin
                dec.inst_type = T_SYSTEM;
                dec.funct = bus.inst[20] ? F_EBREAK : F_ECALL;
            end
            default: dec.opcode = op;
        endcase
    end

`ifdef IDECODER_ILLEGAL_EN
    logic [6:0] f7;
    logic bad;
    assign f7 = bus.inst[31:25];
    always_comb begin
        bad = 1'b1;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            OP_JALR, OP_FENCE: bad = f3 != 3'b000;
            OP_BRANCH: bad = f3[2:1] == 2'b01;
            OP_LOAD: bad = f3 == 3'b011 || f3[2:1] == 2'b11;
            OP_STORE: bad = f3[2] || f3 == 3'b011;
            OP_IMM: bad = f3 == 3'b001 ? f7 != 7'b0 : f3 == 3'b101 ? (f7 & 7'b1011111) != 7'b0 : 1'b0;
            OP_REG: bad = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            OP_SYSTEM: bad = bus.inst != 32'h0000_0073 && bus.inst != 32'h0010_0073;
            default: bad = 1'b1;
        endcase
    end
    assign entry = bad ? entry_t'{opcode: op, pc: bus.in_pc, illegal: 1'b1, default: '0} : dec;
`else
    assign entry = dec;
`endif

    assign valid = state != EMPTY;
    assign bus.in_ready = state != FULL && !rst;
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop = valid && bus.out_ready && !flush;

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
        state_next = flush || count_next == '0 ? EMPTY : count_next == CW'(DEPTH) ? FULL : PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head = valid ? mem[rd_ptr] : '0;
    assign bus.out_valid = valid;
    assign bus.opcode = head.opcode;
    assign bus.inst_type = head.inst_type;
    assign bus.rd = head.rd;
    assign bus.rs1 = head.rs1;
    assign bus.rs2 = head.rs2;
    assign bus.funct = head.funct;
    assign bus.imm = head.imm;
    assign bus.out_pc = head.pc;
    assign bus.illegal = head.illegal;
endmodule

// File: tb/tb_idecoder_pipe.sv
// tb_idecoder_pipe: directed checks of decode, FIFO ordering, back-pressure, flush and reset.
module tb_idecoder_pipe;
    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] inst;
        logic [3:0] t;
        logic [4:0] rd, rs1, rs2, f;
        logic [31:0] imm;
    } vec_t;
    vec_t v [10];

    idecoder_pipe_if #(.XLEN(XLEN)) bus ();
    idecoder_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input vec_t e, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".opcode"}, 32'(bus.opcode), 32'(e.inst[6:0]));
        chk({tag, ".type"}, 32'(bus.inst_type), 32'(e.t));
        chk({tag, ".rd"}, 32'(bus.rd), 32'(e.rd));
        chk({tag, ".rs1"}, 32'(bus.rs1), 32'(e.rs1));
        chk({tag, ".rs2"}, 32'(bus.rs2), 32'(e.rs2));
        chk({tag, ".funct"}, 32'(bus.funct), 32'(e.f));
        chk({tag, ".imm"}, bus.imm, e.imm);
        chk({tag, ".pc"}, bus.out_pc, pc);
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    task automatic drive(input logic val, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = val;
        bus.inst = inst;
        bus.in_pc = pc;
    endtask

    initial begin
        v[0] = '{32'h00500093, 4'd2, 5'd1, 5'd0, 5'd0, 5'd1, 32'h00000005};
        v[1] = '{32'h12345137, 4'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'h12345000};
        v[2] = '{32'h402081B3, 4'd3, 5'd3, 5'd1, 5'd2, 5'd2, 32'h00000000};
        v[3] = '{32'hFE208EE3, 4'd4, 5'd0, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFC};
        v[4] = '{32'h00512423, 4'd9, 5'd0, 5'd2, 5'd5, 5'd19, 32'h00000008};
        v[5] = '{32'hFFC12303, 4'd8, 5'd6, 5'd2, 5'd0, 5'd19, 32'hFFFFFFFC};
        v[6] = '{32'h001000EF, 4'd6, 5'd1, 5'd0, 5'd0, 5'd0, 32'h00000800};
        v[7] = '{32'h4030D393, 4'd2, 5'd7, 5'd1, 5'd0, 5'd14, 32'h00000403};
        v[8] = '{32'h00A4C433, 4'd3, 5'd8, 5'd9, 5'd10, 5'd11, 32'h00000000};
        v[9] = '{32'hFFFFF217, 4'd5, 5'd4, 5'd0, 5'd0, 5'd0, 32'hFFFFF000};
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        repeat (2) step;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
        chk("rst.imm", bus.imm, 32'd0);
        chk("rst.type", 32'(bus.inst_type), 32'd0);
        rst = 1'b0;
        step;
        chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst.out_valid", 32'(bus.out_valid), 32'd0);
        // back-to-back stream: each edge pops the previous head and pushes the next word
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, v[i].inst, 32'h1000 + 32'(4 * i));
            step;
            chk_head($sformatf("stream%0d", i), v[i], 32'h1000 + 32'(4 * i));
            chk($sformatf("stream%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        step;
        chk("drained.out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, v[0].inst, 32'h2000);
        step;
        chk("fill1.in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, v[1].inst, 32'h2004);
        step;
        chk("fill2.in_ready", 32'(bus.in_ready), 32'd0);
        chk_head("fill2", v[0], 32'h2000);
        drive(1'b1, v[2].inst, 32'h2008);
        step;
        chk_head("stall", v[0], 32'h2000);
        chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        step;
        chk_head("pop1", v[1], 32'h2004);
        chk("pop1.in_ready", 32'(bus.in_ready), 32'd1);
        step;
        chk("pop2.out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, v[3].inst, 32'h3000);
        step;
        flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, v[4].inst, 32'h3004);
        step;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush1.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush1.in_ready", 32'(bus.in_ready), 32'd1);
        step;
        chk("flush1.later", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, v[5].inst, 32'h3100);
        step;
        drive(1'b1, v[6].inst, 32'h3104);
        step;
        flush = 1'b1;
        drive(1'b1, v[7].inst, 32'h3108);
        step;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush2.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush2.in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        step;
        chk("flush2.later", 32'(bus.out_valid), 32'd0);
        drive(1'b1, v[8].inst, 32'h3200);
        step;
        chk_head("after_flush", v[8], 32'h3200);
        drive(1'b1, 32'h0000007F, 32'h4000);
        step;
        drive(1'b0, 32'h0, 32'h0);
        chk("ill.valid", 32'(bus.out_valid), 32'd1);
        chk("ill.opcode", 32'(bus.opcode), 32'h7F);
        chk("ill.type", 32'(bus.inst_type), 32'd0);
        chk("ill.pc", bus.out_pc, 32'h4000);
`ifdef IDECODER_ILLEGAL_EN
        chk("ill.flag", 32'(bus.illegal), 32'd1);
`else
        chk("ill.flag", 32'(bus.illegal), 32'd0);
`endif
        step;
        bus.out_ready = 1'b0;
        drive(1'b1, v[9].inst, 32'h5000);
        step;
        drive(1'b0, 32'h0, 32'h0);
        chk_head("pre_rst", v[9], 32'h5000);
        rst = 1'b1;
        step;
        chk("midrst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        step;
        chk("after_rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("after_rst.in_ready", 32'(bus.in_ready), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/idecoder_pipe.md
# idecoder_pipe

Registered, buffered RV32 instruction decoder stage for copperv. It sits between fetch and execute, accepts fetched instruction words over a valid/ready handshake, and decodes the full RV32I base opcode set, not only LUI/OP-IMM/OP/BEQ. Decoded fields go into a parametrised FIFO so execute can stall without back-pressuring fetch immediately. A flush input drops all buffered work on a branch redirect.

## Interface
- `XLEN`, 32: width of `imm` and `pc`.
- `DEPTH`, 2: decoded-entry FIFO depth; power of two, ≥2.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `flush`  in  1  discard all buffered entries and any input this cycle.
- `in_valid`  in  1  `inst`/`in_pc` valid.
- `in_ready`  out  1  stage can accept; equals `!full && !rst`.
- `inst`  in  `INST_WIDTH`  instruction word.
- `in_pc`  in  XLEN  address of `inst`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  execute consumes head.
- `opcode`  out  `OPCODE_WIDTH`  inst[6:0].
- `imm`  out  XLEN  sign-extended immediate, per type.
- `inst_type`  out  `INST_TYPE_WIDTH`  class; adds `INST_TYPE_AUIPC`, `_JAL`, `_JALR`, `_LOAD`, `_STORE` to copperv_h.v.
- `rd`, `rs1`, `rs2`  out  `REG_WIDTH` each  register indices; 0 when unused by the type.
- `funct`  out  `FUNCT_WIDTH`  operation; adds `FUNCT_NE/LT/GE/LTU/GEU/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU` and load/store size codes.
- `out_pc`  out  XLEN  PC of head entry.
- `illegal`  out  1  head entry is an unrecognised encoding.

## Operation
- Decode is combinational on `inst`. The result is written into the FIFO on a push, when `in_valid && in_ready && !flush`.
- Immediate formats:
  - I: `{sext inst[31], inst[30:20]}`.
  - S: `{sext, inst[31:25], inst[11:7]}`.
  - B: `{sext, inst[7], inst[30:25], inst[11:8], 0}`.
  - U: `{inst[31:12], 12'b0}`.
  - J: `{sext, inst[19:12], inst[20], inst[30:21], 0}`.
  - Sign-extend to XLEN.
- Unused fields per type are 0. R-type `funct` is selected from `{inst[31:25], inst[14:12]}`. OP-IMM shifts use inst[30] to select SRL vs SRA.
- FIFO state: read pointer, write pointer, `log2(DEPTH)+1`-bit occupancy count.
  - Pointers wrap modulo DEPTH.
  - `full` = count==DEPTH; `out_valid` = count≠0.
- Pop on `out_valid && out_ready`.
- Push and pop in the same cycle leave the count unchanged. A push is impossible when full (`in_ready`=0), so no write-through.
- Output fields come from the head entry. When `out_valid`=0 they hold 0.
- `flush` has priority. The next cycle has count=0 and pointers=0, and this cycle's push and pop are ignored.
- States: EMPTY (count 0), PARTIAL, FULL.
  - Transitions are by push/pop as above.
  - `flush` goes to EMPTY from any state.

## Timing
- Reset: all outputs 0 (`out_valid`=0, `illegal`=0, fields 0), `in_ready`=0 during reset and 1 the cycle after. Count and pointers are 0. Reset mid-stream discards all entries.
- Latency: instruction accepted at edge N gives `out_valid`=1 with its fields after edge N (visible in cycle N+1).
- Throughput: one instruction per cycle sustained with `out_ready`=1. Sustained throughput needs no bubbles at DEPTH≥2.
- Head fields are stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered count (no combinational path from `out_ready`).

## Configuration
- `IDECODER_ILLEGAL_EN` defined:
  - `illegal`=1 for unrecognised opcode, or reserved funct3/funct7 within a known opcode.
  - Such entries still occupy the FIFO, with fields 0 except `opcode` and `out_pc`.
- Undefined: `illegal` tied to 0. Unrecognised encodings decode to all-zero fields (`inst_type`=0), and no detection logic is synthesised.

## Test plan
- `addi x1,x0,5` (0x00500093), `out_ready`=1 -> next cycle `inst_type`=INT_IMM, rd=1, rs1=0, imm=5, funct=ADD.
- `lui x2,0x12345` (0x12345137) then `sub x3,x1,x2` (0x402081B3) back-to-back:
  - First: imm=0x12345000, rd=2.
  - Second: INT_REG, rs1=1, rs2=2, rd=3, funct=SUB.
  - One output per cycle.
- `beq x1,x2,-4` (0xFE208EE3) -> BRANCH, imm=0xFFFFFFFC, rs1=1, rs2=2, funct=EQ.
- `out_ready`=0, push DEPTH instructions:
  - `in_ready` drops after the DEPTH-th push.
  - Raise `out_ready`: entries emerge in order, and `in_ready` returns the cycle after the first pop.
- Fill 2 entries, assert `flush` together with `in_valid` -> next cycle `out_valid`=0, count 0, flushed input never appears.
- Word 0x0000007F with `IDECODER_ILLEGAL_EN` -> `illegal`=1, `inst_type`=0. Without the macro -> `illegal`=0.
